// File: rtl/fft_pkg.sv
// Shared FFT datapath types: sample format, lane count and the branch-select encoding
// common to the 1-to-2 split and the 2-to-1 merge.
package fft_pkg;

    localparam int FFT_WIDTH = 9;
    localparam int FFT_LANES = 16;

    typedef logic signed [FFT_WIDTH-1:0] sample_t;

    // Identical to the split's sel value, so sel == state when the two stages are paired.
    typedef enum logic {S_CAL = 1'b0, S_REG = 1'b1} merge_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_merge_seq.sv
// Frame sequencer for the 2-to-1 merge: BLK_LEN blocks from cal, then BLK_LEN from reg.
// Owns the FSM, the block counter, the per-branch ready and the registered frame_done.
module fft_merge_seq
    import fft_pkg::*;
#(
    parameter int BLK_LEN = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_cal_valid,
    input  logic         i_reg_valid,
    output logic         o_cal_ready,
    output logic         o_reg_ready,
    output logic         o_acc,
    output logic         o_frame_done,
    output merge_state_t o_state
);

    localparam int CW = cnt_width(BLK_LEN);
    localparam logic [CW-1:0] LAST = CW'(BLK_LEN - 1);

    merge_state_t  r_state;
    merge_state_t  w_state_nxt;
    logic [CW-1:0] r_blk_cnt;
    logic [CW-1:0] w_blk_cnt_nxt;
    logic          r_frame_done;
    logic          w_acc;
    logic          w_last;

    // Valid/ready: a block moves on a cycle where the owning branch has valid and ready
    // both high; ready depends only on state (and reset), never on valid.
    assign o_cal_ready = (r_state == S_CAL) && !rst;
    assign o_reg_ready = (r_state == S_REG) && !rst;
    assign w_acc       = (r_state == S_CAL) ? i_cal_valid : i_reg_valid;
    assign w_last      = (r_blk_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_CAL;
            r_blk_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_blk_cnt    <= w_blk_cnt_nxt;
            r_frame_done <= w_acc && w_last && (r_state == S_REG);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_blk_cnt_nxt = r_blk_cnt;
        if (w_acc) begin
            if (w_last) begin
                w_blk_cnt_nxt = '0;
                w_state_nxt   = (r_state == S_CAL) ? S_REG : S_CAL;
            end else begin
                w_blk_cnt_nxt = r_blk_cnt + 1'b1;
            end
        end
    end

    assign o_acc        = w_acc;
    assign o_frame_done = r_frame_done;
    assign o_state      = r_state;

endmodule

// File: rtl/fft_merge_2to1.sv
// Registered 2-to-1 merge of the cal (butterfly) and reg (delay-line) FFT branches
// into one valid-qualified block stream; lanes are passed through bit-exact.
module fft_merge_2to1
    import fft_pkg::*;
#(
    parameter int WIDTH      = FFT_WIDTH,
    parameter int DATA_WIDTH = FFT_LANES,
    parameter int BLK_LEN    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] din_cal_re [0:DATA_WIDTH-1],
    input  logic signed [WIDTH-1:0] din_cal_im [0:DATA_WIDTH-1],
    input  logic                    din_cal_valid,
    output logic                    din_cal_ready,
    input  logic signed [WIDTH-1:0] din_reg_re [0:DATA_WIDTH-1],
    input  logic signed [WIDTH-1:0] din_reg_im [0:DATA_WIDTH-1],
    input  logic                    din_reg_valid,
    output logic                    din_reg_ready,
    output logic signed [WIDTH-1:0] dout_re    [0:DATA_WIDTH-1],
    output logic signed [WIDTH-1:0] dout_im    [0:DATA_WIDTH-1],
    output logic                    dout_valid,
    output logic                    dout_src,
    output logic                    frame_done
);

    logic                    w_acc;
    merge_state_t            w_state;
    logic signed [WIDTH-1:0] r_dout_re [0:DATA_WIDTH-1];
    logic signed [WIDTH-1:0] r_dout_im [0:DATA_WIDTH-1];
    logic                    r_dout_valid;
    logic                    r_dout_src;

    fft_merge_seq #(
        .BLK_LEN (BLK_LEN)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .i_cal_valid  (din_cal_valid),
        .i_reg_valid  (din_reg_valid),
        .o_cal_ready  (din_cal_ready),
        .o_reg_ready  (din_reg_ready),
        .o_acc        (w_acc),
        .o_frame_done (frame_done),
        .o_state      (w_state)
    );

    // Idle cycles zero the lanes; dout_src keeps naming the last accepted source.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                r_dout_re[i] <= '0;
                r_dout_im[i] <= '0;
            end
            r_dout_valid <= 1'b0;
            r_dout_src   <= 1'b0;
        end else if (w_acc) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                r_dout_re[i] <= (w_state == S_REG) ? din_reg_re[i] : din_cal_re[i];
                r_dout_im[i] <= (w_state == S_REG) ? din_reg_im[i] : din_cal_im[i];
            end
            r_dout_valid <= 1'b1;
            r_dout_src   <= (w_state == S_REG);
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                r_dout_re[i] <= '0;
                r_dout_im[i] <= '0;
            end
            r_dout_valid <= 1'b0;
        end
    end

    assign dout_re    = r_dout_re;
    assign dout_im    = r_dout_im;
    assign dout_valid = r_dout_valid;
    assign dout_src   = r_dout_src;

endmodule

// File: tb/tb_fft_merge_2to1.sv
// Bench for fft_merge_2to1: one instance with BLK_LEN=2 and one with BLK_LEN=1 share all
// inputs; a frame-position model predicts ready, valid, source, frame_done and lanes.
module tb_fft_merge_2to1;

    typedef logic signed [8:0] lanes_t [0:15];

    localparam logic signed [8:0] SMIN = 9'h100;
    localparam logic signed [8:0] SMAX = 9'h0FF;

    logic   clk = 1'b0;
    logic   rst;
    lanes_t cal_re, cal_im, reg_re, reg_im;
    logic   cal_valid, reg_valid;

    lanes_t a_re, a_im, b_re, b_im;
    logic   a_crdy, a_rrdy, a_valid, a_src, a_fd;
    logic   b_crdy, b_rrdy, b_valid, b_src, b_fd;

    always #5 clk = ~clk;

    fft_merge_2to1 #(.WIDTH(9), .DATA_WIDTH(16), .BLK_LEN(2)) dut_a (
        .clk(clk), .rst(rst),
        .din_cal_re(cal_re), .din_cal_im(cal_im), .din_cal_valid(cal_valid), .din_cal_ready(a_crdy),
        .din_reg_re(reg_re), .din_reg_im(reg_im), .din_reg_valid(reg_valid), .din_reg_ready(a_rrdy),
        .dout_re(a_re), .dout_im(a_im), .dout_valid(a_valid), .dout_src(a_src), .frame_done(a_fd)
    );

    fft_merge_2to1 #(.WIDTH(9), .DATA_WIDTH(16), .BLK_LEN(1)) dut_b (
        .clk(clk), .rst(rst),
        .din_cal_re(cal_re), .din_cal_im(cal_im), .din_cal_valid(cal_valid), .din_cal_ready(b_crdy),
        .din_reg_re(reg_re), .din_reg_im(reg_im), .din_reg_valid(reg_valid), .din_reg_ready(b_rrdy),
        .dout_re(b_re), .dout_im(b_im), .dout_valid(b_valid), .dout_src(b_src), .frame_done(b_fd)
    );

    // Index 0 = dut_a (BLK_LEN=2), index 1 = dut_b (BLK_LEN=1).
    lanes_t o_re [2];
    lanes_t o_im [2];
    logic   o_valid [2];
    logic   o_src [2];
    logic   o_fd [2];
    logic   o_crdy [2];
    logic   o_rrdy [2];

    always_comb begin
        o_re[0] = a_re;  o_im[0] = a_im;  o_re[1] = b_re;  o_im[1] = b_im;
        o_valid[0] = a_valid; o_src[0] = a_src; o_fd[0] = a_fd; o_crdy[0] = a_crdy; o_rrdy[0] = a_rrdy;
        o_valid[1] = b_valid; o_src[1] = b_src; o_fd[1] = b_fd; o_crdy[1] = b_crdy; o_rrdy[1] = b_rrdy;
    end

    // Model: position within a frame of 2*BLK_LEN blocks; the first half belongs to cal.
    int     blk [2] = '{2, 1};
    int     m_pos [2];
    logic   e_valid [2];
    logic   e_src [2];
    logic   e_fd [2];
    lanes_t e_re [2];
    lanes_t e_im [2];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [143:0] flat(input lanes_t v);
        logic [143:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*9 +: 9] = v[i];
        return r;
    endfunction

    function automatic logic exp_crdy(input int k);
        return !rst && (m_pos[k] < blk[k]);
    endfunction

    function automatic logic exp_rrdy(input int k);
        return !rst && (m_pos[k] >= blk[k]);
    endfunction

    task automatic rand_lanes(output lanes_t re, output lanes_t im);
        for (int i = 0; i < 16; i++) begin
            re[i] = 9'($urandom_range(0, 511));
            im[i] = 9'($urandom_range(0, 511));
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven, then to the DUTs.
    task automatic advance();
        logic on_reg, acc;
        for (int k = 0; k < 2; k++) begin
            on_reg = (m_pos[k] >= blk[k]);
            acc    = on_reg ? reg_valid : cal_valid;
            if (rst || !acc) begin
                if (rst) begin
                    m_pos[k] = 0;
                    e_src[k] = 1'b0;
                end
                e_valid[k] = 1'b0;
                e_fd[k]    = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    e_re[k][i] = '0;
                    e_im[k][i] = '0;
                end
            end else begin
                if (on_reg) begin
                    e_re[k] = reg_re;
                    e_im[k] = reg_im;
                end else begin
                    e_re[k] = cal_re;
                    e_im[k] = cal_im;
                end
                e_valid[k] = 1'b1;
                e_src[k]   = on_reg;
                e_fd[k]    = (m_pos[k] == 2 * blk[k] - 1);
                m_pos[k]   = (m_pos[k] + 1) % (2 * blk[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cal_valid = 1'b0;
        reg_valid = 1'b0;
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cal_valid = 1'b1;
        reg_valid = 1'b1;
        #1;
        n_vec++;
        if ({a_crdy, a_rrdy, b_crdy, b_rrdy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0000", {a_crdy, a_rrdy, b_crdy, b_rrdy});
        end
        advance();
        advance();
        rst = 1'b0;
        cal_valid = 1'b0;
        reg_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            advance();
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({o_valid[k], o_src[k], o_fd[k], o_crdy[k], o_rrdy[k]} !== 5'b00010) begin
                    n_err++;
                    $display("FAIL idle_ctl dut%0d cyc%0d: got v/s/fd/crdy/rrdy=%b want 00010", k, c,
                             {o_valid[k], o_src[k], o_fd[k], o_crdy[k], o_rrdy[k]});
                end
                n_vec++;
                if ((flat(o_re[k]) | flat(o_im[k])) !== 144'd0) begin
                    n_err++;
                    $display("FAIL idle_lanes dut%0d cyc%0d: got re=%h im=%h want all zero", k, c,
                             flat(o_re[k]), flat(o_im[k]));
                end
            end
        end
    endtask

    task automatic test_frame();
        logic exp_src [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_fd  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        lanes_t want_re, want_im;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cal_re[i] = 9'(i + 1);
            cal_im[i] = -9'(i + 1);
            reg_re[i] = 9'(10 * i);
            reg_im[i] = 9'(10 * i);
        end
        for (int c = 0; c < 4; c++) begin
            cal_valid = (c < 2);
            reg_valid = (c >= 2);
            advance();
            for (int i = 0; i < 16; i++) begin
                want_re[i] = exp_src[c] ? 9'(10 * i) : 9'(i + 1);
                want_im[i] = exp_src[c] ? 9'(10 * i) : -9'(i + 1);
            end
            n_vec++;
            if ({a_valid, a_src, a_fd} !== {1'b1, exp_src[c], exp_fd[c]}) begin
                n_err++;
                $display("FAIL frame_ctl out%0d: got v/s/fd=%b want %b", c + 1, {a_valid, a_src, a_fd},
                         {1'b1, exp_src[c], exp_fd[c]});
            end
            n_vec++;
            if ({flat(a_re), flat(a_im)} !== {flat(want_re), flat(want_im)}) begin
                n_err++;
                $display("FAIL frame_lanes out%0d: got re=%h want %h", c + 1, flat(a_re), flat(want_re));
            end
            n_vec++;
            if ({b_valid, b_src, b_fd, flat(b_re)} !== {e_valid[1], e_src[1], e_fd[1], flat(e_re[1])}) begin
                n_err++;
                $display("FAIL frame_blk1 out%0d: got v/s/fd=%b want %b", c + 1, {b_valid, b_src, b_fd},
                         {e_valid[1], e_src[1], e_fd[1]});
            end
        end
        cal_valid = 1'b0;
        reg_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        rand_lanes(cal_re, cal_im);
        rand_lanes(reg_re, reg_im);
        cal_valid = 1'b1;
        reg_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_vec++;
            if ({a_crdy, a_rrdy} !== {((c / 2) % 2 == 0), ((c / 2) % 2 == 1)}) begin
                n_err++;
                $display("FAIL b2b_ready cyc%0d: got crdy/rrdy=%b%b", c, a_crdy, a_rrdy);
            end
            advance();
            n_vec++;
            if ({a_valid, a_src, a_fd} !== {1'b1, ((c / 2) % 2 == 1), (c == 3 || c == 7)}) begin
                n_err++;
                $display("FAIL b2b_ctl out%0d: got v/s/fd=%b", c + 1, {a_valid, a_src, a_fd});
            end
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({flat(o_re[k]), flat(o_im[k]), o_src[k]} !== {flat(e_re[k]), flat(e_im[k]), e_src[k]}) begin
                    n_err++;
                    $display("FAIL b2b_lanes dut%0d out%0d: got re=%h want %h", k, c + 1,
                             flat(o_re[k]), flat(e_re[k]));
                end
            end
            // Only the block just taken by the BLK_LEN=2 instance is replaced.
            if ((c / 2) % 2 == 0) rand_lanes(cal_re, cal_im);
            else rand_lanes(reg_re, reg_im);
        end
        cal_valid = 1'b0;
        reg_valid = 1'b0;
    endtask

    task automatic test_reg_while_cal();
        do_reset();
        rand_lanes(reg_re, reg_im);
        reg_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({o_crdy[k], o_rrdy[k]} !== 2'b10) begin
                    n_err++;
                    $display("FAIL hold_ready dut%0d cyc%0d: got crdy/rrdy=%b%b want 10", k, c, o_crdy[k], o_rrdy[k]);
                end
            end
            advance();
            n_vec++;
            if ({a_valid, b_valid, a_fd, b_fd} !== 4'b0000) begin
                n_err++;
                $display("FAIL hold_valid cyc%0d: got %b want 0000", c, {a_valid, b_valid, a_fd, b_fd});
            end
        end
        // Counter must not have moved: one cal block keeps BLK_LEN=2 in the cal half.
        reg_valid = 1'b0;
        cal_valid = 1'b1;
        rand_lanes(cal_re, cal_im);
        advance();
        cal_valid = 1'b0;
        #1;
        n_vec++;
        if ({a_valid, a_src, a_crdy, a_rrdy, b_crdy, b_rrdy} !== 6'b101001) begin
            n_err++;
            $display("FAIL hold_after: got %b want 101001", {a_valid, a_src, a_crdy, a_rrdy, b_crdy, b_rrdy});
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            rand_lanes(cal_re, cal_im);
            rand_lanes(reg_re, reg_im);
            cal_valid = (c < 2);
            reg_valid = (c == 2);
            advance();
        end
        rst = 1'b1;
        cal_valid = 1'b0;
        reg_valid = 1'b0;
        advance();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({a_valid, a_src, a_fd, a_crdy, a_rrdy} !== 5'b00010) begin
            n_err++;
            $display("FAIL midrst_state: got v/s/fd/crdy/rrdy=%b want 00010", {a_valid, a_src, a_fd, a_crdy, a_rrdy});
        end
        for (int c = 0; c < 4; c++) begin
            rand_lanes(cal_re, cal_im);
            rand_lanes(reg_re, reg_im);
            cal_valid = (c < 2);
            reg_valid = (c >= 2);
            #1;
            n_vec++;
            if ({a_crdy, a_rrdy} !== {exp_crdy(0), exp_rrdy(0)} || {a_crdy, a_rrdy} !== {(c < 2), (c >= 2)}) begin
                n_err++;
                $display("FAIL midrst_ready cyc%0d: got crdy/rrdy=%b%b", c, a_crdy, a_rrdy);
            end
            advance();
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({o_valid[k], o_src[k], o_fd[k], flat(o_re[k]), flat(o_im[k])} !==
                    {e_valid[k], e_src[k], e_fd[k], flat(e_re[k]), flat(e_im[k])}) begin
                    n_err++;
                    $display("FAIL midrst_out dut%0d cyc%0d: got v/s/fd=%b want %b", k, c,
                             {o_valid[k], o_src[k], o_fd[k]}, {e_valid[k], e_src[k], e_fd[k]});
                end
            end
        end
        cal_valid = 1'b0;
        reg_valid = 1'b0;
    endtask

    task automatic test_extremes();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cal_re[i] = SMIN;
            cal_im[i] = SMAX;
            reg_re[i] = SMAX;
            reg_im[i] = SMIN;
        end
        cal_valid = 1'b1;
        reg_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            advance();
            n_vec++;
            if ({b_valid, b_src, b_fd} !== {1'b1, c[0], c[0]}) begin
                n_err++;
                $display("FAIL ext_ctl out%0d: got v/s/fd=%b want %b", c + 1, {b_valid, b_src, b_fd}, {1'b1, c[0], c[0]});
            end
            for (int i = 0; i < 16; i++) begin
                n_vec++;
                if ({b_re[i], b_im[i]} !== (c[0] ? {SMAX, SMIN} : {SMIN, SMAX})) begin
                    n_err++;
                    $display("FAIL ext_lane%0d out%0d: got re=%0d im=%0d", i, c + 1, b_re[i], b_im[i]);
                end
            end
        end
        cal_valid = 1'b0;
        reg_valid = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 120; c++) begin
            rst       = ($urandom_range(0, 29) == 0);
            cal_valid = 1'($urandom_range(0, 1));
            reg_valid = 1'($urandom_range(0, 1));
            rand_lanes(cal_re, cal_im);
            rand_lanes(reg_re, reg_im);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({o_crdy[k], o_rrdy[k]} !== {exp_crdy(k), exp_rrdy(k)}) begin
                    n_err++;
                    $display("FAIL rand_ready dut%0d cyc%0d: got %b%b want %b%b", k, c,
                             o_crdy[k], o_rrdy[k], exp_crdy(k), exp_rrdy(k));
                end
            end
            advance();
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({o_valid[k], o_src[k], o_fd[k], flat(o_re[k]), flat(o_im[k])} !==
                    {e_valid[k], e_src[k], e_fd[k], flat(e_re[k]), flat(e_im[k])}) begin
                    n_err++;
                    $display("FAIL rand_out dut%0d cyc%0d: got v/s/fd=%b re=%h want %b re=%h", k, c,
                             {o_valid[k], o_src[k], o_fd[k]}, flat(o_re[k]),
                             {e_valid[k], e_src[k], e_fd[k]}, flat(e_re[k]));
                end
            end
        end
        rst = 1'b0;
        cal_valid = 1'b0;
        reg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cal_valid = 1'b0;
        reg_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cal_re[i] = '0; cal_im[i] = '0; reg_re[i] = '0; reg_im[i] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = 0; e_valid[k] = 1'b0; e_src[k] = 1'b0; e_fd[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_frame();
        test_back_to_back();
        test_reg_while_cal();
        test_mid_reset();
        test_extremes();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/fft_merge_2to1.md
Name: fft_merge_2to1

Overview:
- Registered 2-to-1 merge stage that recombines the two branches of the FFT datapath into one stream of DATA_WIDTH-lane complex blocks.
- The "cal" branch carries butterfly results; the "reg" branch carries delay-line data.
- A two-state frame sequencer accepts BLK_LEN blocks from cal, then BLK_LEN blocks from reg, then repeats.
- Per-branch valid/ready handshake; the output is a registered valid-qualified stream for the next stage.

Parameters:
- WIDTH, 9, signed bit width of each real/imag sample.
- DATA_WIDTH, 16, number of complex lanes per block.
- BLK_LEN, 2, blocks taken from each branch per half-frame. Legal range is 1..256.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- din_cal_re  in  signed [WIDTH-1:0] x [0:DATA_WIDTH-1]  cal-branch real lanes.
- din_cal_im  in  signed [WIDTH-1:0] x [0:DATA_WIDTH-1]  cal-branch imag lanes.
- din_cal_valid  in  1  cal block present.
- din_cal_ready  out  1  cal block accepted this cycle when valid&ready.
- din_reg_re  in  signed [WIDTH-1:0] x [0:DATA_WIDTH-1]  reg-branch real lanes.
- din_reg_im  in  signed [WIDTH-1:0] x [0:DATA_WIDTH-1]  reg-branch imag lanes.
- din_reg_valid  in  1  reg block present.
- din_reg_ready  out  1  reg block accepted when valid&ready.
- dout_re  out  signed [WIDTH-1:0] x [0:DATA_WIDTH-1]  merged real lanes, registered.
- dout_im  out  signed [WIDTH-1:0] x [0:DATA_WIDTH-1]  merged imag lanes, registered.
- dout_valid  out  1  dout holds an accepted block this cycle.
- dout_src  out  1  source of the current dout: 0 = cal, 1 = reg.
- frame_done  out  1  one-cycle pulse coinciding with the output of the last reg block of a frame.

Behaviour:
- All state and outputs are updated on the rising edge of clk.
- Reset (rst=1 at a clock edge, any time, including mid-frame):
  - state=S_CAL, blk_cnt=0.
  - dout_re/dout_im all lanes 0, dout_valid=0, dout_src=0, frame_done=0.
  - Any partially merged frame is discarded.
- FSM states: S_CAL and S_REG.
  - din_cal_ready = (state==S_CAL) and not rst.
  - din_reg_ready = (state==S_REG) and not rst.
  - Both ready signals are combinational from state only; they never depend on valid.
- Accept: acc = (S_CAL & din_cal_valid) | (S_REG & din_reg_valid).
- On acc, next cycle:
  - dout_* = the selected branch's lanes, bit-exact with no width change.
  - dout_valid=1, dout_src = (state==S_REG).
- Latency is exactly 1 cycle from the accepting edge to dout_valid.
- No acc: next cycle dout_valid=0, dout_re/dout_im all lanes 0, dout_src holds its previous value, frame_done=0.
- blk_cnt:
  - Width is max(1, $clog2(BLK_LEN)).
  - Increments on acc.
  - When acc and blk_cnt==BLK_LEN-1: blk_cnt wraps to 0 and state toggles (S_CAL->S_REG or S_REG->S_CAL).
- frame_done is registered and asserted together with dout_valid for the block accepted at (S_REG, blk_cnt==BLK_LEN-1).
- Simultaneous valids: only the branch owning the current state is accepted. The other branch sees ready=0 and must hold its data stable (standard valid/ready rule).
- Valid gaps are allowed anywhere; state and blk_cnt hold while no acc.
- With BLK_LEN=1 the state toggles on every accepted block.
- There is no output backpressure; the downstream stage always consumes dout.

Decomposition:
- Shared package fft_pkg holds:
  - Localparams FFT_WIDTH=9 and FFT_LANES=16.
  - typedef logic signed [FFT_WIDTH-1:0] sample_t.
  - typedef enum logic {S_CAL=1'b0, S_REG=1'b1} merge_state_t. The same encoding is reused as the sel value of the existing 1-to-2 split, so that sel==state when the two blocks are paired.
- One natural sub-module: fft_merge_seq, holding the FSM, blk_cnt, ready generation and frame_done. The lane datapath is a flat registered mux in the top.

Test Plan:
1. Reset then idle (both valids 0 for 5 cycles) -> dout_valid=0, all dout lanes 0, din_cal_ready=1, din_reg_ready=0.
2. BLK_LEN=2, cal blocks with lane i = i+1 (re) and -(i+1) (im) on 2 consecutive cycles, then reg blocks lane i = 10*i -> outputs are cal, cal, reg, reg with 1-cycle latency; dout_src = 0,0,1,1; frame_done=1 only on the 4th output.
3. Both valids held high continuously for 8 cycles -> alternating pairs of cal/reg outputs; each idle-side ready is 0 throughout its half; no block is duplicated or dropped; frame_done on output cycles 4 and 8.
4. Reg valid asserted while in S_CAL with cal valid low for 3 cycles -> din_reg_ready=0, no acc, dout_valid=0, state and blk_cnt unchanged.
5. rst asserted for one cycle after 1 reg block in S_REG -> next cycle state=S_CAL, blk_cnt=0, dout_valid=0; the next cal block is counted as block 0.
6. Extreme values: lane re=-256 and im=255 (WIDTH=9), BLK_LEN=1 -> values reproduced bit-exact; dout_src toggles on every accepted block; frame_done follows every reg block.
